// File: rtl/mailbox_pkg.sv
// mailbox_pkg: register map, status bits, data-phase states and AHB encodings for the mailbox slave
package mailbox_pkg;
  localparam logic [3:0] OFF_START   = 4'h0;
  localparam logic [3:0] OFF_FINISH  = 4'h4;
  localparam logic [3:0] OFF_STATUS  = 4'h8;
  localparam logic [3:0] OFF_SCRATCH = 4'hC;
  localparam int ST_ARMED = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_IRQ   = 2;
  localparam logic [31:0] DEF_START_CODE  = 32'h0102_0304;
  localparam logic [31:0] DEF_FINISH_CODE = 32'h0403_0201;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RESP, S_ERR1, S_ERR2} state_e;
endpackage

// File: rtl/ahb_byte_lane_merge.sv
// ahb_byte_lane_merge: overlays little-endian write lanes chosen by hsize/addr onto the old register word
module ahb_byte_lane_merge
  import mailbox_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] merged_o
);
  logic [3:0] be;
  // misaligned half/word accesses fall back to their aligned lanes
  always_comb begin
    be = size_i == HSIZE_WORD ? 4'b1111 :
         size_i == HSIZE_HALF ? (addr_i[1] ? 4'b1100 : 4'b0011) :
         size_i == HSIZE_BYTE ? 4'b0001 << addr_i : 4'b1111;
    for (int i = 0; i < 4; i++) merged_o[8*i +: 8] = be[i] ? wdata_i[8*i +: 8] : old_i[8*i +: 8];
  end
endmodule

// File: rtl/ahb_mailbox_slave.sv
// ahb_mailbox_slave: AHB-Lite start/finish mailbox; define MAILBOX_ERR_RESP_EN for ERROR responses outside the window
module ahb_mailbox_slave
  import mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h5000_0000,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] START_CODE  = DEF_START_CODE,
  parameter logic [31:0] FINISH_CODE = DEF_FINISH_CODE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        AHB_INTERFACE_0_sel,
  input  logic [31:0] AHB_INTERFACE_0_haddr,
  input  logic [1:0]  AHB_INTERFACE_0_htrans,
  input  logic        AHB_INTERFACE_0_hwrite,
  input  logic [2:0]  AHB_INTERFACE_0_hsize,
  input  logic [2:0]  AHB_INTERFACE_0_hburst,
  input  logic [3:0]  AHB_INTERFACE_0_hprot,
  input  logic [31:0] AHB_INTERFACE_0_hwdata,
  input  logic        AHB_INTERFACE_0_hready_in,
  output logic        AHB_INTERFACE_0_hready_out,
  output logic        AHB_INTERFACE_0_hresp,
  output logic [31:0] AHB_INTERFACE_0_hrdata,
  input  logic        host_start_wr,
  input  logic [31:0] host_start_data,
  input  logic        host_finish_clr,
  output logic [31:0] finish_value,
  output logic        done,
  output logic        irq
);
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, size_q;
  logic [3:0]  addr_q, cur_addr;
  logic        write_q, in_q, irq_q, irq_d, done_q;
  logic [31:0] start_q, start_d, finish_q, finish_d, scratch_q, scratch_d, hrdata_q, hrdata_d;
  logic [31:0] status, rd_val, old_word, merged;
  logic        acc, in_win, cur_in, cur_write, rd_fire, rd_clr, wr_fire, unused_ok;
  assign unused_ok = ^{AHB_INTERFACE_0_hburst, AHB_INTERFACE_0_hprot};
  assign in_win = AHB_INTERFACE_0_haddr[31:4] == BASE_ADDR[31:4];
  assign acc = AHB_INTERFACE_0_sel && AHB_INTERFACE_0_hready_in &&
               (AHB_INTERFACE_0_htrans == HTRANS_NONSEQ || AHB_INTERFACE_0_htrans == HTRANS_SEQ) &&
               (state_q == S_IDLE || state_q == S_RESP || state_q == S_ERR2);
  // data-phase sequencing: optional wait countdown, then RESP; back-to-back accepts re-enter directly
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) state_d = S_RESP;
      end
`ifdef MAILBOX_ERR_RESP_EN
      S_ERR1: state_d = S_ERR2;
`endif
      default: begin
        state_d = S_IDLE;
`ifdef MAILBOX_ERR_RESP_EN
        if (acc && !in_win) state_d = S_ERR1;
        else
`endif
        if (acc) begin
          state_d = WAIT_STATES == 0 ? S_RESP : S_WAIT;
          cnt_d = 3'(WAIT_STATES - 1);
        end
      end
    endcase
  end
  // the read that lands in RESP uses the live address phase when zero-wait, else the latched one
  always_comb begin
    cur_addr = state_q == S_WAIT ? addr_q : AHB_INTERFACE_0_haddr[3:0];
    cur_in = state_q == S_WAIT ? in_q : in_win;
    cur_write = state_q == S_WAIT ? write_q : AHB_INTERFACE_0_hwrite;
    status = '0;
    status[ST_ARMED] = start_q == START_CODE;
    status[ST_DONE] = done;
    status[ST_IRQ] = irq_q;
    rd_val = !cur_in ? '0 :
             cur_addr[3:2] == OFF_START[3:2]  ? start_q :
             cur_addr[3:2] == OFF_FINISH[3:2] ? finish_q :
             cur_addr[3:2] == OFF_STATUS[3:2] ? status : scratch_q;
    rd_fire = state_d == S_RESP && !cur_write;
    rd_clr = rd_fire && cur_in && cur_addr[3:2] == OFF_START[3:2] && start_q == START_CODE;
    wr_fire = state_q == S_RESP && write_q && in_q;
    old_word = addr_q[3:2] == OFF_START[3:2]  ? start_q :
               addr_q[3:2] == OFF_FINISH[3:2] ? finish_q : scratch_q;
  end
  ahb_byte_lane_merge u_merge (
    .old_i    (old_word),
    .wdata_i  (AHB_INTERFACE_0_hwdata),
    .size_i   (size_q),
    .addr_i   (addr_q[1:0]),
    .merged_o (merged)
  );
  // register next values with host/AHB/read-clear priorities resolved
  always_comb begin
    start_d = host_start_wr ? host_start_data :
              wr_fire && addr_q[3:2] == OFF_START[3:2] ? merged :
              rd_clr ? '0 : start_q;
    finish_d = wr_fire && addr_q[3:2] == OFF_FINISH[3:2] ? merged :
               host_finish_clr ? '0 : finish_q;
    scratch_d = wr_fire && addr_q[3:2] == OFF_SCRATCH[3:2] ? merged : scratch_q;
    irq_d = done && !done_q ? 1'b1 : host_finish_clr ? 1'b0 : irq_q;
    hrdata_d = rd_fire ? rd_val : hrdata_q;
  end
  // FSM and address-phase capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      size_q <= '0;
      write_q <= 1'b0;
      in_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (acc) begin
        addr_q <= AHB_INTERFACE_0_haddr[3:0];
        size_q <= AHB_INTERFACE_0_hsize;
        write_q <= AHB_INTERFACE_0_hwrite;
        in_q <= in_win;
      end
    end
  end
  // mailbox registers, read data and interrupt edge tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= '0;
      finish_q <= '0;
      scratch_q <= '0;
      hrdata_q <= '0;
      irq_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      start_q <= start_d;
      finish_q <= finish_d;
      scratch_q <= scratch_d;
      hrdata_q <= hrdata_d;
      irq_q <= irq_d;
      done_q <= done;
    end
  end
  assign done = finish_q == FINISH_CODE;
  assign irq = irq_q;
  assign finish_value = finish_q;
  assign AHB_INTERFACE_0_hrdata = hrdata_q;
  assign AHB_INTERFACE_0_hready_out = !(state_q == S_WAIT || state_q == S_ERR1);
`ifdef MAILBOX_ERR_RESP_EN
  assign AHB_INTERFACE_0_hresp = state_q == S_ERR1 || state_q == S_ERR2;
`else
  assign AHB_INTERFACE_0_hresp = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_mailbox_slave.sv
// tb_ahb_mailbox_slave: directed checks of the mailbox slave with zero and three wait states
module tb_ahb_mailbox_slave;
  import mailbox_pkg::*;
  localparam logic [31:0] BASE = 32'h5000_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic        sel = 1'b0, use3 = 1'b0, hwrite = 1'b0, host_start_wr = 1'b0, host_finish_clr = 1'b0;
  logic [31:0] haddr = '0, hwdata = '0, host_start_data = '0;
  logic [1:0]  htrans = '0;
  logic [2:0]  hsize = '0;
  logic        rdy0, rsp0, done0, irq0, rdy3, rsp3, done3, irq3;
  logic [31:0] rd0, fin0, rd3, fin3;
  logic        rdy, rsp, dn, iq;
  logic [31:0] hrd, fin;
  int n_cmp = 0;
  int n_bad = 0;
  ahb_mailbox_slave #(.WAIT_STATES(0)) dut (
    .clk(clk), .reset(reset),
    .AHB_INTERFACE_0_sel(sel && !use3), .AHB_INTERFACE_0_haddr(haddr),
    .AHB_INTERFACE_0_htrans(htrans), .AHB_INTERFACE_0_hwrite(hwrite),
    .AHB_INTERFACE_0_hsize(hsize), .AHB_INTERFACE_0_hburst(3'b000),
    .AHB_INTERFACE_0_hprot(4'b0011), .AHB_INTERFACE_0_hwdata(hwdata),
    .AHB_INTERFACE_0_hready_in(rdy0), .AHB_INTERFACE_0_hready_out(rdy0),
    .AHB_INTERFACE_0_hresp(rsp0), .AHB_INTERFACE_0_hrdata(rd0),
    .host_start_wr(host_start_wr), .host_start_data(host_start_data),
    .host_finish_clr(host_finish_clr), .finish_value(fin0), .done(done0), .irq(irq0)
  );
  ahb_mailbox_slave #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset),
    .AHB_INTERFACE_0_sel(sel && use3), .AHB_INTERFACE_0_haddr(haddr),
    .AHB_INTERFACE_0_htrans(htrans), .AHB_INTERFACE_0_hwrite(hwrite),
    .AHB_INTERFACE_0_hsize(hsize), .AHB_INTERFACE_0_hburst(3'b000),
    .AHB_INTERFACE_0_hprot(4'b0011), .AHB_INTERFACE_0_hwdata(hwdata),
    .AHB_INTERFACE_0_hready_in(rdy3), .AHB_INTERFACE_0_hready_out(rdy3),
    .AHB_INTERFACE_0_hresp(rsp3), .AHB_INTERFACE_0_hrdata(rd3),
    .host_start_wr(host_start_wr), .host_start_data(host_start_data),
    .host_finish_clr(host_finish_clr), .finish_value(fin3), .done(done3), .irq(irq3)
  );
  assign rdy = use3 ? rdy3 : rdy0;
  assign rsp = use3 ? rsp3 : rsp0;
  assign dn  = use3 ? done3 : done0;
  assign iq  = use3 ? irq3 : irq0;
  assign hrd = use3 ? rd3 : rd0;
  assign fin = use3 ? fin3 : fin0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rd, output int waits);
    @(negedge clk);
    sel = 1'b1; htrans = HTRANS_NONSEQ; haddr = a; hwrite = w; hsize = sz;
    @(negedge clk);
    sel = 1'b0; htrans = 2'b00; hwdata = wd; waits = 0;
    while (!rdy && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    rd = hrd;
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp, input int exp_w);
    logic [31:0] r;
    int w;
    xfer(a, 1'b0, HSIZE_WORD, '0, r, w);
    chk({tag, "_waits"}, w, exp_w);
    chk(tag, r, exp);
  endtask
  task automatic wr(input string tag, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d, input int exp_w);
    logic [31:0] r;
    int w;
    xfer(a, 1'b1, sz, d, r, w);
    chk({tag, "_waits"}, w, exp_w);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hready", rdy, 1);
    chk("rst_hresp", rsp, 0);
    chk("rst_hrdata", hrd, 0);
    chk("rst_finish", fin, 0);
    chk("rst_done", dn, 0);
    chk("rst_irq", iq, 0);
    chk("rst_hready3", rdy3, 1);
    reset = 1'b0;
    @(negedge clk);
    host_start_wr = 1'b1; host_start_data = 32'h0102_0304;
    @(negedge clk);
    host_start_wr = 1'b0;
    rd_chk("start_rd", BASE, 32'h0102_0304, 0);
    rd_chk("status_after_arm", BASE + 8, 0, 0);
    rd_chk("start_rd2", BASE, 0, 0);
    wr("fin_wr", BASE + 4, HSIZE_WORD, 32'h0403_0201, 0);
    chk("done_in_resp", dn, 0);
    @(negedge clk);
    chk("done_after_resp", dn, 1);
    chk("finish_value", fin, 32'h0403_0201);
    chk("irq_lag", iq, 0);
    @(negedge clk);
    chk("irq_set", iq, 1);
    rd_chk("status_done_irq", BASE + 8, 32'h6, 0);
    @(negedge clk);
    host_finish_clr = 1'b1;
    @(negedge clk);
    host_finish_clr = 1'b0;
    chk("clr_finish", fin, 0);
    chk("clr_done", dn, 0);
    chk("clr_irq", iq, 0);
    wr("scr_wr", BASE + 12, HSIZE_WORD, 32'h1122_3344, 0);
    wr("scr_byte", BASE + 13, HSIZE_BYTE, 32'h0000_EE00, 0);
    rd_chk("scr_byte_rd", BASE + 12, 32'h1122_EE44, 0);
    wr("scr_half_mis", BASE + 15, HSIZE_HALF, 32'hBEEF_0000, 0);
    rd_chk("scr_half_rd", BASE + 12, 32'hBEEF_EE44, 0);
`ifdef MAILBOX_ERR_RESP_EN
    @(negedge clk);
    sel = 1'b1; htrans = HTRANS_NONSEQ; haddr = BASE + 16; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(negedge clk);
    sel = 1'b0; htrans = 2'b00; hwdata = 32'hDEAD_BEEF;
    chk("err1_hready", rdy, 0);
    chk("err1_hresp", rsp, 1);
    @(negedge clk);
    chk("err2_hready", rdy, 1);
    chk("err2_hresp", rsp, 1);
    @(negedge clk);
    chk("err_end_hresp", rsp, 0);
`else
    wr("oow_wr", BASE + 16, HSIZE_WORD, 32'hDEAD_BEEF, 0);
    chk("oow_wr_hresp", rsp, 0);
    rd_chk("oow_rd", BASE + 16, 0, 0);
    chk("oow_rd_hresp", rsp, 0);
`endif
    rd_chk("scr_untouched", BASE + 12, 32'hBEEF_EE44, 0);
    wr("fin_vs_clr", BASE + 4, HSIZE_WORD, 32'h0403_0201, 0);
    host_finish_clr = 1'b1;
    @(negedge clk);
    chk("fin_wr_beats_clr", fin, 32'h0403_0201);
    chk("fin_wr_done", dn, 1);
    @(negedge clk);
    host_finish_clr = 1'b0;
    chk("edge_beats_clr_irq", iq, 1);
    chk("edge_beats_clr_fin", fin, 0);
    host_finish_clr = 1'b1;
    @(negedge clk);
    host_finish_clr = 1'b0;
    chk("irq_cleared", iq, 0);
    use3 = 1'b1;
    wr("w3_scr_wr", BASE + 12, HSIZE_WORD, 32'hA5A5_5A5A, 3);
    rd_chk("w3_scr_rd", BASE + 12, 32'hA5A5_5A5A, 3);
    @(negedge clk);
    sel = 1'b1; htrans = HTRANS_NONSEQ; haddr = BASE + 4; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(negedge clk);
    sel = 1'b0; htrans = 2'b00; hwdata = 32'h0403_0201;
    chk("w3_in_wait", rdy, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wait_hready", rdy, 1);
    chk("rst_wait_hresp", rsp, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_wait_finish", fin, 0);
    chk("rst_wait_done", dn, 0);
    rd_chk("rst_wait_fin_rd", BASE + 4, 0, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_mailbox_slave.md
# ahb_mailbox_slave

AHB-Lite responder holding the accelerator start/finish mailbox at BASE_ADDR (default 0x5000_0000), serving the start/end sequencer's polling read of START (+0x0) and its finish-code write to FINISH (+0x4). The host side posts the start code, observes completion via `done`/`irq`, and clears FINISH. Single clock domain, placed between the AHB interconnect and host control logic.

## Interface
- BASE_ADDR, 32'h5000_0000: mailbox base; a 16-byte window is decoded.
- WAIT_STATES, 0: data-phase wait cycles inserted on every OKAY transfer (0–7).
- START_CODE, 32'h0102_0304: value that arms the accelerator.
- FINISH_CODE, 32'h0403_0201: value that signals completion.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- AHB_INTERFACE_0_sel  in  1  slave select.
- AHB_INTERFACE_0_haddr  in  32  address.
- AHB_INTERFACE_0_htrans  in  2  transfer type; bit1 = NONSEQ/SEQ.
- AHB_INTERFACE_0_hwrite  in  1  1 = write.
- AHB_INTERFACE_0_hsize  in  3  0 = byte, 1 = half, 2 = word.
- AHB_INTERFACE_0_hburst  in  3  ignored (singles only).
- AHB_INTERFACE_0_hprot  in  4  ignored.
- AHB_INTERFACE_0_hwdata  in  32  write data, valid in the data phase.
- AHB_INTERFACE_0_hready_in  in  1  bus HREADY.
- AHB_INTERFACE_0_hready_out  out  1  slave ready.
- AHB_INTERFACE_0_hresp  out  1  0 = OKAY, 1 = ERROR.
- AHB_INTERFACE_0_hrdata  out  32  read data.
- host_start_wr  in  1  pulse: START <= host_start_data.
- host_start_data  in  32  start value.
- host_finish_clr  in  1  pulse: FINISH <= 0.
- finish_value  out  32  current FINISH register.
- done  out  1  FINISH == FINISH_CODE.
- irq  out  1  level interrupt, set on a done rising edge, cleared by host_finish_clr.

## Operation
- Registers: +0x0 START (RW), +0x4 FINISH (RW), +0x8 STATUS (RO: bit0 = START==START_CODE, bit1 = done, bit2 = irq), +0xC SCRATCH (RW).
- Address phase is accepted when sel && htrans[1] && hready_in. The module latches addr[3:0], hwrite, hsize, and an in-window flag (haddr[31:4] == BASE_ADDR[31:4]).
- Data-phase FSM states: IDLE, WAIT (counts WAIT_STATES), RESP, ERR1, ERR2.
  - IDLE goes to WAIT, or to RESP when WAIT_STATES = 0.
  - WAIT goes to RESP.
  - RESP goes back to IDLE, or re-enters the data phase when another address phase is accepted in the same cycle.
- Writes take hwdata in the RESP cycle. Byte lanes are set by hsize and addr[1:0], little-endian. Misaligned half/word writes are masked to aligned lanes. STATUS writes are ignored.
- Reads: hrdata is registered and valid in RESP. A read of START that returns START_CODE clears START to 0 in the same cycle (one-shot arm).
- Priority for simultaneous events:
  - START: host_start_wr beats an AHB write, which beats read-clear.
  - FINISH: an AHB write beats host_finish_clr.
  - irq: a new done edge beats host_finish_clr.
- Out-of-window accesses without the macro: OKAY response, read returns 0, write is ignored.
- Reset mid-transfer: the FSM returns to IDLE and every output returns to its reset value in the next cycle. No partial write is committed.

## Timing
- Reset values: hready_out = 1, hresp = 0, hrdata = 0, START = FINISH = SCRATCH = 0, done = 0, irq = 0, finish_value = 0.
- OKAY transfer:
  - hready_out = 0 for exactly WAIT_STATES cycles after the address phase.
  - hready_out = 1 in RESP.
  - Zero-wait back-to-back transfers run at full rate.
- Read latency is 1 + WAIT_STATES cycles from the address phase to valid hrdata.
- A register write becomes visible on done, finish_value and STATUS one cycle after RESP. irq follows done by one more cycle.

## Configuration
- MAILBOX_ERR_RESP_EN defined: an out-of-window access gives a two-cycle ERROR response instead of the OKAY behaviour.
  - ERR1: hready_out = 0, hresp = 1.
  - ERR2: hready_out = 1, hresp = 1.
  - Writes are dropped; WAIT_STATES is not applied.
- Undefined: the OKAY behaviour in Operation applies, and the ERR states are not built.

## Structure
- Package `mailbox_pkg` holds: register offsets, the STATUS bit indices, the FSM state enum, default START_CODE/FINISH_CODE, and the HTRANS/HSIZE encodings.
- One sub-module, `ahb_byte_lane_merge`, is used: combinational (old word, hwdata, hsize, addr[1:0]) -> merged word. It is shared by all RW registers.

## Test plan
- Host writes 0x01020304; AHB word read of 0x5000_0000 with WAIT_STATES = 0 -> hrdata = 0x01020304 one cycle after the address phase; STATUS.bit0 then reads 0; a second read returns 0.
- AHB word write 0x04030201 to 0x5000_0004 -> done = 1 one cycle after RESP, irq = 1 the cycle after; host_finish_clr -> FINISH = 0, irq = 0, done = 0.
- WAIT_STATES = 3, read of 0x5000_000C after a SCRATCH write of 0xA5A5_5A5A -> hready_out low 3 cycles, then hrdata = 0xA5A5_5A5A.
- Byte write 0xEE to 0x5000_000D over SCRATCH = 0x1122_3344 -> SCRATCH = 0x1122_EE44.
- Access to 0x5000_0010 -> with MAILBOX_ERR_RESP_EN: hresp = 1 for 2 cycles with hready_out 0 then 1; without it: OKAY, hrdata = 0.
- Same-cycle AHB FINISH write and host_finish_clr -> FINISH = 0x04030201; reset asserted during WAIT -> next cycle hready_out = 1, hresp = 0, no register changed.
